// File: rtl/touchpad_ctrl.sv
// -----------------------------------------------------------------------------
// touchpad_ctrl
//   Serial master for an ADS7843-class resistive touchscreen ADC. Polls the X,
//   Y and Z (pressure) channels in turn. Each frame sends an 8-bit command,
//   waits one busy period and reads back a 12-bit conversion. The upper 9 bits
//   of each conversion are kept in a per-channel output register.
//
// Ports
//   cclk        in   system clock; all logic on its rising edge
//   rstb        in   synchronous active-high reset
//   touch_busy  in   ADC BUSY pin; not used for sequencing
//   data_in     in   serial data from the ADC (DOUT)
//   touch_clk   out  serial clock to the ADC (DCLK), low when idle
//   data_out    out  serial data to the ADC (DIN), MSB first
//   touch_csb   out  active-low chip select
//   x, y, z     out  latest 9-bit samples per channel
// -----------------------------------------------------------------------------
module touchpad_ctrl #(
    parameter int CLK_DIV  = 8,
    parameter int GAP_CLKS = 4
) (
    input  logic       cclk,
    input  logic       rstb,
    input  logic       touch_busy,
    input  logic       data_in,
    output logic       touch_clk,
    output logic       data_out,
    output logic       touch_csb,
    output logic [8:0] x,
    output logic [8:0] y,
    output logic [8:0] z
);

    localparam int DIV_W     = $clog2(CLK_DIV);
    localparam int GAP_TICKS = GAP_CLKS * 2;
    localparam int GAP_W     = $clog2(GAP_TICKS + 1);

    localparam logic [7:0] CMD_X = 8'hD0;
    localparam logic [7:0] CMD_Y = 8'h90;
    localparam logic [7:0] CMD_Z = 8'hB0;

    typedef enum logic [2:0] {
        ST_GAP  = 3'd0,
        ST_CMD  = 3'd1,
        ST_BUSY = 3'd2,
        ST_READ = 3'd3,
        ST_PAD  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CH_X = 2'd0,
        CH_Y = 2'd1,
        CH_Z = 2'd2
    } chan_t;

    // Command byte for the channel being converted.
    function automatic logic [7:0] cmd_for(input chan_t ch);
        logic [7:0] c;
        case (ch)
            CH_X:    c = CMD_X;
            CH_Y:    c = CMD_Y;
            CH_Z:    c = CMD_Z;
            default: c = CMD_X;
        endcase
        return c;
    endfunction

    // Frame phase that owns a given period number.
    function automatic state_t state_for(input logic [4:0] p);
        state_t s;
        if (p < 5'd8) begin
            s = ST_CMD;
        end else if (p == 5'd8) begin
            s = ST_BUSY;
        end else if (p <= 5'd20) begin
            s = ST_READ;
        end else begin
            s = ST_PAD;
        end
        return s;
    endfunction

    // Channel rotation X -> Y -> Z -> X.
    function automatic chan_t next_chan(input chan_t ch);
        chan_t n;
        case (ch)
            CH_X:    n = CH_Y;
            CH_Y:    n = CH_Z;
            CH_Z:    n = CH_X;
            default: n = CH_X;
        endcase
        return n;
    endfunction

    logic [DIV_W-1:0] div_q,   div_d;
    logic [GAP_W-1:0] gap_q,   gap_d;
    logic [4:0]       bit_q,   bit_d;
    logic [11:0]      shift_q, shift_d;
    state_t           state_q, state_d;
    chan_t            chan_q,  chan_d;
    logic             tclk_q,  tclk_d;
    logic             dout_q,  dout_d;
    logic             csb_q,   csb_d;
    logic [8:0]       x_q, x_d, y_q, y_d, z_q, z_d;

    logic             tick_s;
    logic [4:0]       bit_nx_s;
    logic [7:0]       cmd_s;
    logic             busy_unused_s;

    // BUSY is deliberately ignored: sequencing is purely clock-count based.
    assign busy_unused_s = touch_busy;

    // Next-state logic: divider, gap timing and the frame sequencer.
    always_comb begin
        div_d    = div_q;
        gap_d    = gap_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        state_d  = state_q;
        chan_d   = chan_q;
        tclk_d   = tclk_q;
        dout_d   = dout_q;
        csb_d    = csb_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;

        tick_s   = (div_q == DIV_W'(CLK_DIV - 1));
        bit_nx_s = bit_q + 5'd1;
        cmd_s    = cmd_for(chan_q);

        if (tick_s) begin
            div_d = {DIV_W{1'b0}};
        end else begin
            div_d = div_q + {{(DIV_W-1){1'b0}}, 1'b1};
        end

        if (!tick_s) begin
            tclk_d = tclk_q;
        end else if (state_q == ST_GAP) begin
            if (gap_q == GAP_W'(GAP_TICKS - 1)) begin
                // Frame start: select the ADC with the first command bit already valid.
                csb_d   = 1'b0;
                tclk_d  = 1'b0;
                dout_d  = cmd_s[7];
                bit_d   = 5'd0;
                shift_d = 12'd0;
                gap_d   = {GAP_W{1'b0}};
                state_d = ST_CMD;
            end else begin
                gap_d = gap_q + {{(GAP_W-1){1'b0}}, 1'b1};
            end
        end else if (!tclk_q) begin
            // Rising tick: the ADC drives DOUT for this period, capture it.
            tclk_d = 1'b1;
            if (state_q == ST_READ) begin
                shift_d = {shift_q[10:0], data_in};
            end else begin
                shift_d = shift_q;
            end
        end else begin
            // Falling tick: close the current period.
            tclk_d = 1'b0;
            if (bit_q == 5'd23) begin
                csb_d   = 1'b1;
                dout_d  = 1'b0;
                gap_d   = {GAP_W{1'b0}};
                state_d = ST_GAP;
                chan_d  = next_chan(chan_q);
                case (chan_q)
                    CH_X:    x_d = shift_q[11:3];
                    CH_Y:    y_d = shift_q[11:3];
                    CH_Z:    z_d = shift_q[11:3];
                    default: x_d = x_q;
                endcase
            end else begin
                bit_d   = bit_nx_s;
                state_d = state_for(bit_nx_s);
                // Present the next period's bit now so it is stable at the rise.
                if (bit_nx_s < 5'd8) begin
                    dout_d = cmd_s[3'd7 - bit_nx_s[2:0]];
                end else begin
                    dout_d = 1'b0;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge cclk) begin
        if (rstb) begin
            div_q   <= {DIV_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
            bit_q   <= 5'd0;
            shift_q <= 12'd0;
            state_q <= ST_GAP;
            chan_q  <= CH_X;
            tclk_q  <= 1'b0;
            dout_q  <= 1'b0;
            csb_q   <= 1'b1;
            x_q     <= 9'd0;
            y_q     <= 9'd0;
            z_q     <= 9'd0;
        end else begin
            div_q   <= div_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            state_q <= state_d;
            chan_q  <= chan_d;
            tclk_q  <= tclk_d;
            dout_q  <= dout_d;
            csb_q   <= csb_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
        end
    end

    assign touch_clk = tclk_q;
    assign data_out  = dout_q;
    assign touch_csb = csb_q;
    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;

endmodule

// File: tb/tb_touchpad_ctrl.sv
module tb_touchpad_ctrl;

    logic       cclk;
    logic       rstb;
    logic       touch_busy;
    logic       data_in;
    logic       touch_clk;
    logic       data_out;
    logic       touch_csb;
    logic [8:0] x;
    logic [8:0] y;
    logic [8:0] z;

    touchpad_ctrl #(.CLK_DIV(8), .GAP_CLKS(4)) dut (
        .cclk       (cclk),
        .rstb       (rstb),
        .touch_busy (touch_busy),
        .data_in    (data_in),
        .touch_clk  (touch_clk),
        .data_out   (data_out),
        .touch_csb  (touch_csb),
        .x          (x),
        .y          (y),
        .z          (z)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    // mode: 0 busy=0, 1 busy=1, 2 busy toggling, 3 busy=X
    typedef struct packed {
        logic [11:0] word;
        logic [1:0]  mode;
    } frame_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [8:0] ex;
        logic [8:0] ey;
        logic [8:0] ez;
    } exp_t;

    frame_t frame_q[$];
    exp_t   exp_q[$];

    int         checks;
    int         errors;
    int         frames_done;
    int         rise_cnt;
    logic [7:0] cmd_cap;
    logic [11:0] cur_word;
    logic [1:0] cur_mode;
    logic       tog;
    frame_t     mdl_f;
    exp_t       mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic add_frame(input logic [11:0] w, input logic [1:0] m, input bit expect_it,
                             input logic [7:0] c, input logic [8:0] ex, input logic [8:0] ey,
                             input logic [8:0] ez);
        frame_t f;
        exp_t   e;
        f.word = w;
        f.mode = m;
        frame_q.push_back(f);
        if (expect_it) begin
            e.cmd = c;
            e.ex  = ex;
            e.ey  = ey;
            e.ez  = ez;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_frames(input int n);
        int c;
        c = 0;
        while (frames_done < n && c < 20000) begin
            @(negedge cclk);
            c++;
        end
        if (frames_done < n) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout actual=%0d required=%0d", frames_done, n);
        end
    endtask

    task automatic check_reset_values();
        check("rst_csb",  {31'd0, touch_csb}, 32'd1);
        check("rst_clk",  {31'd0, touch_clk}, 32'd0);
        check("rst_dout", {31'd0, data_out},  32'd0);
        check("rst_x",    {23'd0, x},         32'd0);
        check("rst_y",    {23'd0, y},         32'd0);
        check("rst_z",    {23'd0, z},         32'd0);
    endtask

    // Device model: frame start and command capture on DCLK rising edges.
    always @(posedge touch_clk or negedge touch_csb) begin
        if (touch_csb === 1'b0 && touch_clk === 1'b0) begin
            rise_cnt = 0;
            cmd_cap  = 8'h00;
            if (frame_q.size() > 0) begin
                mdl_f    = frame_q.pop_front();
                cur_word = mdl_f.word;
                cur_mode = mdl_f.mode;
            end else begin
                cur_word = 12'h000;
                cur_mode = 2'd0;
            end
        end else if (touch_clk === 1'b1 && touch_csb === 1'b0) begin
            if (rise_cnt < 8) cmd_cap = {cmd_cap[6:0], data_out};
            rise_cnt++;
        end
    end

    // Device model: DOUT for the upcoming period, and BUSY pattern.
    always @(negedge cclk) begin
        int idx;
        idx = 20 - rise_cnt;
        if (touch_csb === 1'b0 && rise_cnt >= 9 && rise_cnt <= 20) data_in = cur_word[idx];
        else data_in = 1'b0;
        tog = ~tog;
        case (cur_mode)
            2'd0:    touch_busy = 1'b0;
            2'd1:    touch_busy = 1'b1;
            2'd2:    touch_busy = tog;
            2'd3:    touch_busy = 1'bx;
            default: touch_busy = 1'b0;
        endcase
    end

    // Monitor: each completed frame (csb rising outside reset) pops one expectation.
    initial begin
        forever begin
            @(posedge touch_csb);
            if (rstb !== 1'b1) begin
                @(negedge cclk);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame actual=%0d required=0", frames_done + 1);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("cmd",   {24'd0, cmd_cap}, {24'd0, mon_e.cmd});
                    check("rises", rise_cnt,         32'd24);
                    check("x",     {23'd0, x},       {23'd0, mon_e.ex});
                    check("y",     {23'd0, y},       {23'd0, mon_e.ey});
                    check("z",     {23'd0, z},       {23'd0, mon_e.ez});
                end
                frames_done++;
            end
        end
    end

    // Stimulus.
    initial begin
        int c;
        checks      = 0;
        errors      = 0;
        frames_done = 0;
        rise_cnt    = 0;
        cmd_cap     = 8'h00;
        cur_word    = 12'h000;
        cur_mode    = 2'd0;
        tog         = 1'b0;
        rstb        = 1'b1;
        data_in     = 1'b0;
        touch_busy  = 1'b0;

        add_frame(12'hABC, 2'd0, 1'b1, 8'hD0, 9'h157, 9'h000, 9'h000);
        add_frame(12'hFFF, 2'd0, 1'b1, 8'h90, 9'h157, 9'h1FF, 9'h000);
        add_frame(12'h008, 2'd0, 1'b1, 8'hB0, 9'h157, 9'h1FF, 9'h001);
        add_frame(12'h000, 2'd0, 1'b1, 8'hD0, 9'h000, 9'h1FF, 9'h001);
        add_frame(12'h3C3, 2'd0, 1'b0, 8'h00, 9'h000, 9'h000, 9'h000);

        repeat (10) @(negedge cclk);
        check_reset_values();
        rstb = 1'b0;

        c = 0;
        while (touch_csb !== 1'b0 && c < 200) begin
            @(negedge cclk);
            c++;
        end
        check("first_csb_fall", c, 32'd64);

        c = 0;
        while (touch_clk !== 1'b1 && c < 100) begin
            @(negedge cclk);
            c++;
        end
        check("first_rise", c, 32'd8);

        c = 0;
        while (touch_clk !== 1'b0 && c < 100) begin
            @(negedge cclk);
            c++;
        end
        while (touch_clk !== 1'b1 && c < 100) begin
            @(negedge cclk);
            c++;
        end
        check("clk_period", c, 32'd16);

        wait_frames(4);

        // Abort the Y frame during period 12.
        c = 0;
        while (!(touch_csb === 1'b0 && rise_cnt == 13) && c < 2000) begin
            @(negedge cclk);
            c++;
        end
        check("reach_period12", rise_cnt, 32'd13);
        rstb = 1'b1;
        @(negedge cclk);
        check_reset_values();
        add_frame(12'h123, 2'd1, 1'b1, 8'hD0, 9'h024, 9'h000, 9'h000);
        add_frame(12'h5A5, 2'd2, 1'b1, 8'h90, 9'h024, 9'h0B4, 9'h000);
        add_frame(12'h7F0, 2'd3, 1'b1, 8'hB0, 9'h024, 9'h0B4, 9'h0FE);
        repeat (2) @(negedge cclk);
        rstb = 1'b0;

        wait_frames(7);
        check("sb_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/touchpad_ctrl.md
Name: touchpad_ctrl

Overview:
- SPI-style master for an ADS7843-class resistive touchscreen ADC.
- Continuously polls three channels in order X, Y, Z. For each channel it sends an 8-bit command, reads back a 12-bit conversion and keeps the upper 9 bits.
- Sits between the system clock domain (cclk) and the touchscreen pins. It exposes the latest X/Y/Z samples as registered 9-bit buses.

Parameters:
- CLK_DIV, 8: cclk cycles per touch_clk half-period; must be >= 2.
- GAP_CLKS, 4: idle touch_clk periods with touch_csb high between frames.

Ports:
- cclk  in  1  system clock; all logic on its rising edge.
- rstb  in  1  reset, synchronous, active-high (asserted when 1).
- touch_busy  in  1  BUSY pin from ADC. Not used for sequencing. Any value, including X, must not affect outputs.
- data_in  in  1  serial data from ADC (DOUT).
- touch_clk  out  1  serial clock to ADC (DCLK); low when idle.
- data_out  out  1  serial data to ADC (DIN); commands MSB first.
- touch_csb  out  1  chip select, active-low.
- x  out  9  latest X sample.
- y  out  9  latest Y sample.
- z  out  9  latest Z (pressure) sample.

Behaviour:
- Reset (rstb=1 at a cclk edge):
  - touch_clk=0, data_out=0, touch_csb=1, x=y=z=0.
  - Divider counter=0, channel=X, state=GAP with gap count 0.
  - Reset takes effect mid-frame; the partial frame is discarded and no output is updated.
- Divider: counts 0..CLK_DIV-1 on cclk. At terminal count it emits a "tick" and wraps.
  - While touch_csb is low, touch_clk toggles on each tick.
  - Rising tick: the tick that drives touch_clk 0->1. Falling tick: the tick that drives it 1->0.
- Frame: 24 touch_clk periods, numbered 0..23, entered from GAP.
  - touch_csb falls on a tick, with touch_clk=0 and data_out = command bit 7.
  - The next tick is the rising edge of period 0.
  - data_out changes only on falling ticks, presenting the bit for the next period. It is therefore stable across every rising edge.
- Commands (MSB first), all with S=1, 12-bit mode, differential, PD=00:
  - X = 0xD0.
  - Y = 0x90.
  - Z = 0xB0.
- Periods 0-7 (CMD): shift out command bits 7..0.
- Period 8 (BUSY): data_out=0.
- Periods 9-20 (READ): on each rising tick, sample data_in into a 12-bit shift register, MSB first. The period 9 sample is bit 11.
- Periods 21-23 (PAD): data_out=0; data_in ignored.
- Frame end: on the falling tick ending period 23:
  - touch_clk returns to 0, touch_csb goes to 1 and data_out goes to 0.
  - The selected output register loads shift[11:3], a truncation with no rounding.
  - Only that register changes; the other two hold.
  - Channel advances X->Y->Z->X.
- GAP: touch_csb high and touch_clk low for GAP_CLKS*2 ticks, then the next frame starts.
- States: GAP, CMD, BUSY, READ, PAD. Transitions occur only on ticks.
- Outputs x/y/z are registers that change only at frame end or reset.
- Bit counter is 5 bits wide and cleared at each frame start.

Test Plan:
- Reset: hold rstb=1 for 10 cycles -> touch_csb=1, touch_clk=0, data_out=0, x=y=z=0. After release, the first csb fall comes after 8 ticks (GAP_CLKS=4). Also check period = 2*CLK_DIV cclk cycles.
- Command capture: a device model samples data_out on touch_clk rising edges -> first three frames decode 0xD0, 0x90, 0xB0. The 24th rise is followed by csb rise.
- Conversion: model drives 12-bit 0xABC in periods 9-20 of the X frame -> x=0x157 after frame end; y and z stay 0.
- Full cycle: model returns 0xFFF for Y and 0x008 for Z -> y=0x1FF, z=0x001. The next X frame with 0x000 gives x=0.
- Mid-frame reset: assert rstb during period 12 of a Y frame -> outputs go immediately to reset values. The next frame is X and y is not updated with partial data.
- touch_busy held X/1/toggling -> identical sequence and outputs to the touch_busy=0 case.
